// File: rtl/conditioning_pkg.sv
// Shared definitions for the conditioning chain: sequencer state encoding and
// the bit layout of the 18-bit conditioning vector.
package conditioning_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BBM_HI    = 3'd1,
    ST_SAMPLE_HI = 3'd2,
    ST_BBM_LO    = 3'd3,
    ST_SAMPLE_LO = 3'd4
  } az_state_e;

  localparam int OUT_W     = 18;
  localparam int AZMUX_LSB = 0;
  localparam int AZMUX_W   = 4;
  localparam int HIMUX_LSB = 4;
  localparam int HIMUX_W   = 4;
  localparam int PC_BIT    = 8;
  localparam int LED_BIT   = 9;
  localparam int MON_LSB   = 10;
  localparam int MON_W     = 8;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter used to time each sequencer phase; stops at zero
// instead of wrapping.
module phase_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_zero,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_count <= '0;
    else if (i_load)
      r_count <= i_val;
    else if (r_count != '0)
      r_count <= r_count - CNT_W'(1);
  end

  assign o_zero  = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/az_sequencer.sv
// Auto-zero sequencer: alternates signal and zero phases of the azmux with
// break-before-make gaps. Optional debug monitor field: AZ_SEQ_MONITOR_EN.
module az_sequencer
  import conditioning_pkg::*;
#(
  parameter int BBM_CYCLES = 4,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] clk_count_hi,
  input  logic [CNT_W-1:0] clk_count_lo,
  input  logic [2:0]       azmux_hi_val,
  input  logic [2:0]       azmux_lo_val,
  input  logic [3:0]       himux_val,
  output logic [OUT_W-1:0] out,
  output logic             sample_done
);

  localparam logic [CNT_W-1:0] BBM_LAST = CNT_W'(BBM_CYCLES - 1);

  az_state_e        r_state;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_lo_cnt;
  logic [3:0]       r_azmux;
  logic [3:0]       r_himux;
  logic             r_pc;
  logic             r_led;
  logic             r_done;

  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_zero;
  logic [CNT_W-1:0] w_count;
  logic             w_done_nxt;
  logic [MON_W-1:0] w_mon;

  // Timer holds (duration - 1); a zero duration still gives one cycle.
  function automatic logic [CNT_W-1:0] last_index(input logic [CNT_W-1:0] c);
    last_index = (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_val   (w_load_val),
    .o_zero  (w_zero),
    .o_count (w_count)
  );

  // Timer reload on each phase exit; sample_done is predicted one cycle
  // early so that the registered pulse lands on the last SAMPLE_LO cycle.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load     = 1'b1;
        w_load_val = enable ? BBM_LAST : '0;
      end
      ST_BBM_HI: if (w_zero) begin
        w_load     = 1'b1;
        w_load_val = last_index(r_hi_cnt);
      end
      ST_SAMPLE_HI: if (w_zero) begin
        w_load     = 1'b1;
        w_load_val = BBM_LAST;
      end
      ST_BBM_LO: if (w_zero) begin
        w_load     = 1'b1;
        w_load_val = last_index(r_lo_cnt);
        w_done_nxt = (last_index(r_lo_cnt) == '0);
      end
      ST_SAMPLE_LO: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = enable ? BBM_LAST : '0;
        end else begin
          w_done_nxt = (w_count == CNT_W'(1));
        end
      end
      default: w_load = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
      r_azmux  <= '0;
      r_himux  <= '0;
      r_pc     <= 1'b0;
      r_led    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_himux <= himux_val;
      r_done  <= w_done_nxt;
      if (w_done_nxt)
        r_led <= ~r_led;
      case (r_state)
        ST_IDLE: begin
          r_azmux <= '0;
          r_pc    <= 1'b0;
          if (enable) begin
            r_state  <= ST_BBM_HI;
            r_hi_cnt <= clk_count_hi;
            r_lo_cnt <= clk_count_lo;
            r_pc     <= 1'b1;
          end
        end
        ST_BBM_HI: if (w_zero) begin
          r_state <= ST_SAMPLE_HI;
          r_azmux <= {1'b1, azmux_hi_val};
        end
        ST_SAMPLE_HI: if (w_zero) begin
          r_state    <= ST_BBM_LO;
          r_azmux[3] <= 1'b0;
          r_pc       <= 1'b0;
        end
        ST_BBM_LO: if (w_zero) begin
          r_state <= ST_SAMPLE_LO;
          r_azmux <= {1'b1, azmux_lo_val};
        end
        ST_SAMPLE_LO: if (w_zero) begin
          if (enable) begin
            r_state    <= ST_BBM_HI;
            r_hi_cnt   <= clk_count_hi;
            r_lo_cnt   <= clk_count_lo;
            r_azmux[3] <= 1'b0;
            r_pc       <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_azmux <= '0;
            r_pc    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef AZ_SEQ_MONITOR_EN
  logic [MON_W-1:0] r_mon;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_mon <= '0;
    else
      r_mon <= {r_done, enable, r_pc, r_azmux[3], 1'b0, r_state};
  end

  assign w_mon = r_mon;
`else
  assign w_mon = '0;
`endif

  always_comb begin
    out                          = '0;
    out[AZMUX_LSB +: AZMUX_W]    = r_azmux;
    out[HIMUX_LSB +: HIMUX_W]    = r_himux;
    out[PC_BIT]                  = r_pc;
    out[LED_BIT]                 = r_led;
    out[MON_LSB +: MON_W]        = w_mon;
  end

  assign sample_done = r_done;

endmodule

// File: tb/tb_az_sequencer.sv
// Scoreboard bench for az_sequencer: phase segments and sample_done events are
// predicted from phase durations and compared by an independent monitor.
module tb_az_sequencer;

  localparam int BBM = 4;
  localparam int CW  = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] clk_count_hi = '0;
  logic [CW-1:0] clk_count_lo = '0;
  logic [2:0]    azmux_hi_val = '0;
  logic [2:0]    azmux_lo_val = '0;
  logic [3:0]    himux_val = '0;
  logic [17:0]   out;
  logic          sample_done;

  az_sequencer #(.BBM_CYCLES(BBM), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .clk_count_hi (clk_count_hi),
    .clk_count_lo (clk_count_lo),
    .azmux_hi_val (azmux_hi_val),
    .azmux_lo_val (azmux_lo_val),
    .himux_val    (himux_val),
    .out          (out),
    .sample_done  (sample_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] az; logic pc; int len; } seg_t;
  typedef struct { int cyc; logic led; } done_t;

  seg_t  seg_q[$];
  done_t done_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  logic [3:0] hm_exp = '0;
  logic [4:0] cur = '0;
  int    cur_len = 0;
  logic [4:0] v_now;
  seg_t  s_mon;
  done_t d_mon;
  logic  led_exp = 1'b0;
  logic [2:0] prev_addr = '0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    hm_exp <= reset_n ? himux_val : 4'd0;
  end

  // Monitor: a segment is a maximal run of constant {azmux, sw_pc_ctl}.
  always @(negedge clk) begin
    v_now = {out[3:0], out[8]};
    if (v_now == cur) begin
      cur_len++;
    end else begin
      check("direct_addr_switch", int'(cur[4] & v_now[4]), 0);
      if (seg_q.size() == 0) begin
        check("unexpected_segment", int'(v_now), int'(cur));
      end else begin
        s_mon = seg_q.pop_front();
        check("seg_azmux", int'(cur[4:1]), int'(s_mon.az));
        check("seg_pc", int'(cur[0]), int'(s_mon.pc));
        if (s_mon.len != 0)
          check("seg_len", cur_len, s_mon.len);
      end
      cur     = v_now;
      cur_len = 1;
    end
    check("himux", int'(out[7:4]), int'(hm_exp));
    check("monitor_field", int'(out[17:10]), 0);
    if (sample_done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", int'(sample_done), 0);
      end else begin
        d_mon = done_q.pop_front();
        check("done_cycle", cyc, d_mon.cyc);
        check("led", int'(out[9]), int'(d_mon.led));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(input logic [CW-1:0] c);
    return (c == '0) ? 1 : int'(c);
  endfunction

  task automatic push_idle();
    seg_t s;
    s.az = 4'd0; s.pc = 1'b0; s.len = 0;
    seg_q.push_back(s);
    prev_addr = 3'd0;
  endtask

  // One phase of the expected timeline; we enter just before its first edge.
  task automatic do_phase(input logic [3:0] az, input logic pc, input int len,
                          input bit want_done, input bit rnd, input int drop_at,
                          input int set_at, input int set_val, input int rst_at,
                          output bit aborted);
    seg_t  s;
    done_t d;
    aborted = 1'b0;
    s.az  = az;
    s.pc  = pc;
    s.len = (rst_at >= 0 && rst_at < len) ? rst_at + 1 : len;
    seg_q.push_back(s);
    for (int i = 0; i < len; i++) begin
      step();
      himux_val = 4'($urandom);
      if (i == rst_at) begin
        reset_n = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (i == drop_at) enable = 1'b0;
      if (i == set_at) clk_count_hi = CW'(set_val);
      if (rnd && i < len - 1 && $urandom_range(0, 3) == 0) begin
        azmux_hi_val = 3'($urandom);
        azmux_lo_val = 3'($urandom);
        clk_count_hi = CW'($urandom_range(0, 12));
        clk_count_lo = CW'($urandom_range(0, 12));
      end
      if (want_done && i == len - 1) begin
        led_exp = ~led_exp;
        d.cyc   = cyc;
        d.led   = led_exp;
        done_q.push_back(d);
      end
    end
  endtask

  task automatic az_cycle(input bit rnd, input int drop_at, input int set_at,
                          input int set_val, input int rst_at, output bit aborted);
    int hc, lc;
    logic [2:0] ha, la;
    bit ab;
    hc = eff(clk_count_hi);
    lc = eff(clk_count_lo);
    do_phase({1'b0, prev_addr}, 1'b1, BBM, 1'b0, rnd, -1, -1, 0, -1, ab);
    ha = azmux_hi_val;
    do_phase({1'b1, ha}, 1'b1, hc, 1'b0, rnd, drop_at, -1, 0, -1, ab);
    do_phase({1'b0, ha}, 1'b0, BBM, 1'b0, rnd, -1, -1, 0, -1, ab);
    la = azmux_lo_val;
    do_phase({1'b1, la}, 1'b0, lc, 1'b1, rnd, -1, set_at, set_val, rst_at, ab);
    prev_addr = la;
    aborted   = ab;
    if (ab) return;
    if (!enable) push_idle();
  endtask

  task automatic after_reset();
    step();
    check("rst_out", int'(out), 0);
    check("rst_done", int'(sample_done), 0);
    led_exp = 1'b0;
    push_idle();
    reset_n = 1'b1;
  endtask

  initial begin
    bit ab;
    push_idle();
    reset_n = 1'b0;
    repeat (3) step();
    check("init_out", int'(out), 0);
    check("init_done", int'(sample_done), 0);
    reset_n = 1'b1;
    step();

    // Nominal 10/6 timing, then hi count changed mid SAMPLE_LO.
    clk_count_hi = 24'd10; clk_count_lo = 24'd6;
    azmux_hi_val = 3'd5;   azmux_lo_val = 3'd2;
    enable = 1'b1;
    repeat (3) az_cycle(1'b0, -1, -1, 0, -1, ab);
    az_cycle(1'b0, -1, 1, 50, -1, ab);
    az_cycle(1'b0, -1, -1, 0, -1, ab);

    // Enable dropped during SAMPLE_HI: cycle completes, then IDLE.
    az_cycle(1'b0, 3, -1, 0, -1, ab);
    repeat (5) step();
    check("idle_azmux", int'(out[3:0]), 0);

    // Zero counts behave as one cycle.
    clk_count_hi = '0; clk_count_lo = '0;
    enable = 1'b1;
    repeat (3) az_cycle(1'b0, -1, -1, 0, -1, ab);

    // Randomized counts, addresses and occasional enable drops.
    for (int k = 0; k < 12; k++) begin
      az_cycle(1'b1, ($urandom_range(0, 4) == 0) ? 0 : -1, -1, 0, -1, ab);
      if (!enable) begin
        repeat ($urandom_range(1, 4)) step();
        clk_count_hi = CW'($urandom_range(0, 12));
        clk_count_lo = CW'($urandom_range(0, 12));
        enable = 1'b1;
      end
    end

    // Reset one cycle before the end of SAMPLE_LO: no pulse, immediate zero.
    clk_count_hi = 24'd3; clk_count_lo = 24'd5;
    az_cycle(1'b0, -1, -1, 0, 3, ab);
    check("rst_aborted", int'(ab), 1);
    after_reset();
    clk_count_lo = 24'd2;
    repeat (2) az_cycle(1'b0, -1, -1, 0, -1, ab);
    az_cycle(1'b0, 0, -1, 0, -1, ab);
    repeat (6) step();

    check("end_azmux", int'(out[3:0]), 0);
    check("end_seg_pending", seg_q.size(), 1);
    check("end_done_pending", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/az_sequencer.md
AZ_SEQUENCER -- requirements
Module: az_sequencer

Interface
REQ-001 The block SHALL have parameter BBM_CYCLES, default 4, giving the break-before-make gap in clk cycles (minimum 1).
REQ-002 The block SHALL have parameter CNT_W, default 24, giving the width of the phase counter and duration inputs.
REQ-003 The block SHALL have port clk, input, 1, the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1, which requests auto-zero cycling.
REQ-006 The block SHALL have port clk_count_hi, input, CNT_W, giving the signal-phase duration in clk cycles.
REQ-007 The block SHALL have port clk_count_lo, input, CNT_W, giving the zero-phase duration in clk cycles.
REQ-008 The block SHALL have port azmux_hi_val, input, 3, the azmux address used during the signal phase.
REQ-009 The block SHALL have port azmux_lo_val, input, 3, the azmux address used during the zero phase.
REQ-010 The block SHALL have port himux_val, input, 4, the himux {EN,A2,A1,A0} value passed through.
REQ-011 The block SHALL have port out, output, 18, the conditioning vector {monitor[7:0], led, sw_pc_ctl, himux[3:0], azmux[3:0]} that feeds the mode mux.
REQ-012 The block SHALL have port sample_done, output, 1, a one-cycle pulse at the end of each completed auto-zero cycle.

Function
REQ-013 The FSM SHALL have five states, encoded IDLE=0, BBM_HI=1, SAMPLE_HI=2, BBM_LO=3, SAMPLE_LO=4.
REQ-014 In IDLE, azmux SHALL be 4'b0000, sw_pc_ctl SHALL be 0 and the counter SHALL hold 0; if enable=1, the FSM SHALL move to BBM_HI on the next edge.
REQ-015 On entry to BBM_HI, clk_count_hi and clk_count_lo SHALL be latched, so later input changes only take effect at the next cycle start.
REQ-016 Each BBM state SHALL last exactly BBM_CYCLES cycles, with azmux EN=0 and the address bits holding their previous value.
REQ-017 SAMPLE_HI SHALL last exactly the latched hi count cycles, with azmux={1,azmux_hi_val} and sw_pc_ctl=1.
REQ-018 SAMPLE_LO SHALL last exactly the latched lo count cycles, with azmux={1,azmux_lo_val} and sw_pc_ctl=0.
REQ-019 sw_pc_ctl SHALL change only in the first cycle of a BBM state: to 1 in BBM_HI and to 0 in BBM_LO.
REQ-020 A latched count of 0 SHALL be treated as 1, and the counter SHALL never wrap.
REQ-021 At the last cycle of SAMPLE_LO, sample_done SHALL be 1 for exactly that cycle, led SHALL toggle, and the next state SHALL be BBM_HI if enable=1, otherwise IDLE.
REQ-022 If enable falls mid-cycle, the current cycle SHALL complete, including sample_done, before the FSM returns to IDLE.
REQ-023 A change of azmux_hi_val or azmux_lo_val mid-phase SHALL NOT alter azmux until the next entry to that phase.
REQ-024 himux SHALL be himux_val registered with one cycle of latency, independent of FSM state.
REQ-025 All of out SHALL be registered, with no combinational path from inputs to out.

Reset
REQ-026 When reset_n=0 at a rising edge, the next state SHALL be IDLE, out SHALL be 18'b0, sample_done SHALL be 0, the counter SHALL be 0 and the latched counts SHALL be 0.
REQ-027 Reset asserted mid-phase SHALL abort the cycle immediately, with no sample_done pulse.
REQ-028 After reset_n rises with enable=1, the first BBM_HI cycle SHALL occur on the second edge.

Configuration
REQ-029 With AZ_SEQ_MONITOR_EN defined, monitor SHALL be {sample_done, enable, sw_pc_ctl, azmux EN, 1'b0, state[2:0]}, registered.
REQ-030 Without AZ_SEQ_MONITOR_EN, monitor SHALL be 8'b0 and the associated logic SHALL be absent.

Structure
REQ-031 The state encodings, the out bit-field positions (AZMUX_LSB=0, HIMUX_LSB=4, PC_BIT=8, LED_BIT=9, MON_LSB=10) and the 18-bit vector width SHALL be defined in shared package conditioning_pkg, also used by the top level.
REQ-032 One sub-module SHALL be used: phase_timer, a loadable CNT_W-bit down-counter with load input and zero flag, instantiated once.

Verification
REQ-033 The bench SHALL check: hi=10, lo=6, BBM=4, enable held -> period 24 cycles, one sample_done per 24 cycles, and led toggling each period.
REQ-034 The bench SHALL check: across every phase transition, azmux EN is 0 for exactly 4 cycles between the hi and lo addresses, and azmux never switches directly between addresses.
REQ-035 The bench SHALL check: clk_count_hi changed from 10 to 50 mid-SAMPLE_LO -> the current cycle is unchanged and the next SAMPLE_HI lasts 50 cycles.
REQ-036 The bench SHALL check: enable dropped in SAMPLE_HI -> the cycle completes, exactly one sample_done occurs, then IDLE with azmux=0.
REQ-037 The bench SHALL check: reset_n=0 asserted in SAMPLE_LO -> the next edge gives out=0 and no sample_done.
REQ-038 The bench SHALL check: hi=0, lo=0 -> each SAMPLE phase lasts 1 cycle and the period is 10 cycles.
